// File: rtl/sd_block_writer_if.sv
// rtl/sd_block_writer_if.sv - byte-exchange handshake between the block writer and the SPI engine
interface sd_block_writer_if;
  logic       spi_start;
  logic [7:0] spi_data_in;
  logic       spi_done;
  logic [7:0] spi_data_out;

  modport master (output spi_start, spi_data_in, input spi_done, spi_data_out);
  modport slave  (input spi_start, spi_data_in, output spi_done, spi_data_out);
endinterface

// File: rtl/sd_block_writer.sv
// rtl/sd_block_writer.sv - writes one frame-buffer image to an SDHC card as CMD24 single-block writes
module sd_block_writer #(
  parameter int BLOCKS_PER_IMAGE = 300,
  parameter int R1_TIMEOUT       = 8,
  parameter int BUSY_TIMEOUT     = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               image_index,
  sd_block_writer_if.master        spi,
  output logic                     sd_cs_n,
  output logic [16:0]              fb_addr,
  input  logic [15:0]              fb_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_R1, S_TOKEN, S_FETCH, S_DATA_HI, S_DATA_LO,
    S_CRC, S_DRESP, S_BUSY, S_NEXT, S_FINISH
  } state_t;

  localparam logic [15:0] R1_LAST    = 16'(R1_TIMEOUT - 1);
  localparam logic [15:0] BUSY_LAST  = 16'(BUSY_TIMEOUT - 1);
  localparam logic [8:0]  BLOCK_LAST = 9'(BLOCKS_PER_IMAGE - 1);

  state_t      state, state_nx;
  logic        pending, pending_nx;
  logic [2:0]  byte_cnt, byte_cnt_nx;
  logic [15:0] poll_cnt, poll_cnt_nx;
  logic        fetch_wait, fetch_wait_nx;
  logic [8:0]  block_idx, block_idx_nx;
  logic [16:0] pix_cnt, pix_cnt_nx;
  logic [15:0] pixel, pixel_nx;
  logic [1:0]  img, img_nx;
  logic        spi_start_q, spi_start_nx;
  logic [7:0]  spi_data_q, spi_data_nx;
  logic        cs_n_nx, busy_nx, done_nx, error_nx;
  logic        tx_req, fail, finish;
  logic [7:0]  tx_byte, cmd_byte;
  logic [31:0] blk_addr;
  logic        rx;
  logic [7:0]  rx_byte;

  assign spi.spi_start   = spi_start_q;
  assign spi.spi_data_in = spi_data_q;
  assign fb_addr         = pix_cnt;
  assign rx              = pending & spi.spi_done;
  assign rx_byte         = spi.spi_data_out;
  assign blk_addr        = 32'(img) * 32'(BLOCKS_PER_IMAGE) + 32'(block_idx);

  always_comb begin
    case (byte_cnt)
      3'd0:    cmd_byte = 8'h58;
      3'd1:    cmd_byte = blk_addr[31:24];
      3'd2:    cmd_byte = blk_addr[23:16];
      3'd3:    cmd_byte = blk_addr[15:8];
      3'd4:    cmd_byte = blk_addr[7:0];
      default: cmd_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_nx      = state;
    pending_nx    = pending;
    byte_cnt_nx   = byte_cnt;
    poll_cnt_nx   = poll_cnt;
    fetch_wait_nx = fetch_wait;
    block_idx_nx  = block_idx;
    pix_cnt_nx    = pix_cnt;
    pixel_nx      = pixel;
    img_nx        = img;
    spi_start_nx  = 1'b0;
    spi_data_nx   = spi_data_q;
    cs_n_nx       = sd_cs_n;
    busy_nx       = busy;
    done_nx       = 1'b0;
    error_nx      = error;
    tx_req        = 1'b0;
    tx_byte       = 8'hFF;
    fail          = 1'b0;
    finish        = 1'b0;

    case (state)
      S_IDLE: if (start) begin
        state_nx     = S_CMD;
        error_nx     = 1'b0;
        busy_nx      = 1'b1;
        cs_n_nx      = 1'b0;
        block_idx_nx = '0;
        pix_cnt_nx   = '0;
        byte_cnt_nx  = '0;
        pending_nx   = 1'b0;
        img_nx       = image_index;
      end
      S_CMD: begin
        if (!pending) begin
          tx_req  = 1'b1;
          tx_byte = cmd_byte;
        end else if (rx) begin
          pending_nx = 1'b0;
          if (byte_cnt == 3'd5) begin
            state_nx    = S_R1;
            poll_cnt_nx = '0;
          end else begin
            byte_cnt_nx = byte_cnt + 3'd1;
          end
        end
      end
      S_R1: begin
        if (!pending) begin
          tx_req = 1'b1;
        end else if (rx) begin
          pending_nx  = 1'b0;
          poll_cnt_nx = poll_cnt + 16'd1;
          if (rx_byte == 8'hFF) fail = (poll_cnt == R1_LAST);
          else if (rx_byte == 8'h00) state_nx = S_TOKEN;
          else fail = 1'b1;
        end
      end
      S_TOKEN: begin
        if (!pending) begin
          tx_req  = 1'b1;
          tx_byte = 8'hFE;
        end else if (rx) begin
          pending_nx    = 1'b0;
          state_nx      = S_FETCH;
          fetch_wait_nx = 1'b0;
        end
      end
      // fb_data follows fb_addr by one cycle; the high byte is launched as the word is latched
      S_FETCH: begin
        if (!fetch_wait) begin
          fetch_wait_nx = 1'b1;
        end else begin
          pixel_nx = fb_data;
          tx_req   = 1'b1;
          tx_byte  = fb_data[15:8];
          state_nx = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (!pending) begin
          tx_req  = 1'b1;
          tx_byte = pixel[15:8];
        end else if (rx) begin
          pending_nx = 1'b0;
          state_nx   = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (!pending) begin
          tx_req  = 1'b1;
          tx_byte = pixel[7:0];
        end else if (rx) begin
          pending_nx = 1'b0;
          if (pix_cnt[7:0] == 8'hFF) begin
            state_nx    = S_CRC;
            byte_cnt_nx = '0;
          end else begin
            pix_cnt_nx    = pix_cnt + 17'd1;
            state_nx      = S_FETCH;
            fetch_wait_nx = 1'b0;
          end
        end
      end
      S_CRC: begin
        if (!pending) begin
          tx_req = 1'b1;
        end else if (rx) begin
          pending_nx = 1'b0;
          if (byte_cnt == 3'd1) begin
            state_nx    = S_DRESP;
            poll_cnt_nx = '0;
          end else begin
            byte_cnt_nx = byte_cnt + 3'd1;
          end
        end
      end
      S_DRESP: begin
        if (!pending) begin
          tx_req = 1'b1;
        end else if (rx) begin
          pending_nx  = 1'b0;
          poll_cnt_nx = poll_cnt + 16'd1;
          if (rx_byte == 8'hFF) fail = (poll_cnt == R1_LAST);
          else if (rx_byte[4:0] == 5'b00101) begin
            state_nx    = S_BUSY;
            poll_cnt_nx = '0;
          end else fail = 1'b1;
        end
      end
      S_BUSY: begin
        if (!pending) begin
          tx_req = 1'b1;
        end else if (rx) begin
          pending_nx = 1'b0;
          if (rx_byte != 8'h00) state_nx = S_NEXT;
          else if (poll_cnt == BUSY_LAST) fail = 1'b1;
          else poll_cnt_nx = poll_cnt + 16'd1;
        end
      end
      // chip select is left low between blocks; only FINISH releases it
      S_NEXT: begin
        if (block_idx == BLOCK_LAST) begin
          finish = 1'b1;
        end else begin
          block_idx_nx = block_idx + 9'd1;
          pix_cnt_nx   = pix_cnt + 17'd1;
          byte_cnt_nx  = '0;
          state_nx     = S_CMD;
        end
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase

    if (tx_req) begin
      spi_start_nx = 1'b1;
      spi_data_nx  = tx_byte;
      pending_nx   = 1'b1;
    end
    if (fail) begin
      error_nx = 1'b1;
      finish   = 1'b1;
    end
    if (finish) begin
      state_nx   = S_FINISH;
      pending_nx = 1'b0;
      cs_n_nx    = 1'b1;
      busy_nx    = 1'b0;
      done_nx    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pending     <= 1'b0;
      byte_cnt    <= '0;
      poll_cnt    <= '0;
      fetch_wait  <= 1'b0;
      block_idx   <= '0;
      pix_cnt     <= '0;
      pixel       <= '0;
      img         <= '0;
      spi_start_q <= 1'b0;
      spi_data_q  <= 8'hFF;
      sd_cs_n     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_nx;
      pending     <= pending_nx;
      byte_cnt    <= byte_cnt_nx;
      poll_cnt    <= poll_cnt_nx;
      fetch_wait  <= fetch_wait_nx;
      block_idx   <= block_idx_nx;
      pix_cnt     <= pix_cnt_nx;
      pixel       <= pixel_nx;
      img         <= img_nx;
      spi_start_q <= spi_start_nx;
      spi_data_q  <= spi_data_nx;
      sd_cs_n     <= cs_n_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      error       <= error_nx;
    end
  end

endmodule

// File: tb/tb_sd_block_writer.sv
// tb/tb_sd_block_writer.sv - randomized bench with SPI engine, SD card and frame-buffer models
module tb_sd_block_writer;
  localparam int BLK = 3;
  localparam int R1T = 8;
  localparam int BT  = 16;
  localparam int P_CMD = 0, P_R1 = 1, P_TOK = 2, P_DATA = 3, P_CRC = 4, P_DR = 5, P_BUSY = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  image_index = 2'd0;
  logic        sd_cs_n;
  logic [16:0] fb_addr;
  logic [15:0] fb_data;
  logic        busy, done, error;
  logic [15:0] fb_mem [0:1023];

  sd_block_writer_if spi_bus ();

  sd_block_writer #(.BLOCKS_PER_IMAGE(BLK), .R1_TIMEOUT(R1T), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .reset(reset), .start(start), .image_index(image_index), .spi(spi_bus),
    .sd_cs_n(sd_cs_n), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .done(done), .error(error)
  );

  initial forever #5 clk = ~clk;

  always_ff @(posedge clk) fb_data <= fb_mem[fb_addr[9:0]];

  int n_checks = 0, n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // card behaviour for the current run
  int         r1_pad, busy_n;
  logic [7:0] r1_val, dresp_val;
  int         phase = P_CMD, cnt = 0, fe_cnt = 0, n_done = 0;
  int         proto_err = 0, cs_err = 0, addr_err = 0, lat = 0;
  bit         outstanding = 1'b0, done_prev = 1'b0, arm_rst = 1'b0, lo_hit = 1'b0;
  logic [7:0] resp = 8'hFF;
  logic [7:0] tx[$];
  logic [7:0] exp_q[$];

  task automatic card_step(input logic [7:0] b, output logic [7:0] r);
    r = 8'hFF;
    case (phase)
      P_CMD: begin
        cnt++;
        if (cnt == 6) begin phase = P_R1; cnt = 0; end
      end
      P_R1: begin
        if (cnt < r1_pad) cnt++;
        else begin
          r = r1_val;
          if (r1_val == 8'h00) phase = P_TOK;
          else if (r1_val != 8'hFF) phase = P_CMD;
          cnt = 0;
        end
      end
      P_TOK: if (b == 8'hFE) begin fe_cnt++; phase = P_DATA; cnt = 0; end
      P_DATA: begin
        if (fb_addr != 17'((fe_cnt - 1) * 256 + cnt / 2)) addr_err++;
        if (arm_rst && fe_cnt == 2 && cnt == 101) lo_hit = 1'b1;
        cnt++;
        if (cnt == 512) begin phase = P_CRC; cnt = 0; end
      end
      P_CRC: begin
        cnt++;
        if (cnt == 2) begin phase = P_DR; cnt = 0; end
      end
      P_DR: begin
        r = dresp_val;
        phase = (dresp_val[4:0] == 5'b00101) ? P_BUSY : P_CMD;
      end
      P_BUSY: begin
        if (cnt < busy_n) begin r = 8'h00; cnt++; end
        else begin r = 8'($urandom_range(1, 255)); phase = P_CMD; cnt = 0; end
      end
      default: phase = P_CMD;
    endcase
  endtask

  // SPI engine: latches each byte on spi_start, answers 1-2 cycles later with a spi_done pulse
  initial begin
    spi_bus.spi_done = 1'b0;
    spi_bus.spi_data_out = 8'hFF;
    forever begin
      @(negedge clk);
      done_prev = spi_bus.spi_done;
      spi_bus.spi_done = 1'b0;
      if (reset) begin
        outstanding = 1'b0;
        phase = P_CMD;
        cnt = 0;
      end else begin
        if (done) n_done++;
        if (sd_cs_n == busy) cs_err++;
        if (spi_bus.spi_start) begin
          if (outstanding || done_prev || sd_cs_n) proto_err++;
          else begin
            tx.push_back(spi_bus.spi_data_in);
            card_step(spi_bus.spi_data_in, resp);
            outstanding = 1'b1;
            lat = $urandom_range(1, 2);
          end
        end else if (outstanding) begin
          lat--;
          if (lat == 0) begin
            spi_bus.spi_done = 1'b1;
            spi_bus.spi_data_out = resp;
            outstanding = 1'b0;
          end
        end
      end
    end
  end

  // expected MOSI stream derived from the protocol rules
  task automatic build_exp(input int img, output bit err, output int fe);
    logic [31:0] a;
    logic [15:0] px;
    exp_q.delete();
    err = 1'b0;
    fe = 0;
    for (int b = 0; b < BLK && !err; b++) begin
      a = 32'(img * BLK + b);
      exp_q.push_back(8'h58);
      exp_q.push_back(a[31:24]); exp_q.push_back(a[23:16]);
      exp_q.push_back(a[15:8]);  exp_q.push_back(a[7:0]);
      exp_q.push_back(8'hFF);
      if (r1_val == 8'hFF) begin
        repeat (R1T) exp_q.push_back(8'hFF);
        err = 1'b1;
      end else begin
        repeat (r1_pad + 1) exp_q.push_back(8'hFF);
        if (r1_val != 8'h00) err = 1'b1;
        else begin
          exp_q.push_back(8'hFE);
          fe++;
          for (int w = 0; w < 256; w++) begin
            px = fb_mem[b * 256 + w];
            exp_q.push_back(px[15:8]);
            exp_q.push_back(px[7:0]);
          end
          repeat (3) exp_q.push_back(8'hFF);
          if (dresp_val[4:0] != 5'b00101) err = 1'b1;
          else if (busy_n >= BT) begin
            repeat (BT) exp_q.push_back(8'hFF);
            err = 1'b1;
          end else begin
            repeat (busy_n + 1) exp_q.push_back(8'hFF);
          end
        end
      end
    end
  endtask

  task automatic set_card(input int pad, input logic [7:0] r1, input logic [7:0] dr, input int bn);
    r1_pad = pad; r1_val = r1; dresp_val = dr; busy_n = bn;
  endtask

  task automatic prep();
    tx.delete();
    fe_cnt = 0; n_done = 0; addr_err = 0; proto_err = 0; cs_err = 0;
    phase = P_CMD; cnt = 0;
  endtask

  task automatic run_image(input string tag, input int img, input bit poke_busy, input bit poke_done);
    bit exp_err;
    int exp_fe;
    int first_diff;
    bit seen;
    prep();
    build_exp(img, exp_err, exp_fe);
    seen = 1'b0;
    first_diff = -1;
    @(negedge clk); #1;
    image_index = 2'(img);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check($sformatf("%s/busy_after_start", tag), 32'(busy), 32'd1);
    check($sformatf("%s/cs_after_start", tag), 32'(sd_cs_n), 32'd0);
    check($sformatf("%s/error_cleared", tag), 32'(error), 32'd0);
    check($sformatf("%s/no_early_spi", tag), 32'(spi_bus.spi_start), 32'd0);
    @(negedge clk); #1;
    check($sformatf("%s/first_spi", tag), {23'd0, spi_bus.spi_start, spi_bus.spi_data_in}, 32'h158);
    for (int k = 0; k < 30000 && !seen; k++) begin
      @(negedge clk); #1;
      start = poke_busy && (k == 300);
      if (poke_busy && k == 300) image_index = image_index + 2'd1;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) check($sformatf("%s/done_timeout", tag), 32'd0, 32'd1);
    else begin
      check($sformatf("%s/busy_at_done", tag), 32'(busy), 32'd0);
      check($sformatf("%s/error_at_done", tag), 32'(error), 32'(exp_err));
      if (poke_done) begin
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        check($sformatf("%s/start_in_done_ignored", tag), 32'(busy), 32'd0);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < tx.size() && i < exp_q.size(); i++)
      if (first_diff < 0 && tx[i] != exp_q[i]) first_diff = i;
    check($sformatf("%s/done_count", tag), 32'(n_done), 32'd1);
    check($sformatf("%s/error_final", tag), 32'(error), 32'(exp_err));
    check($sformatf("%s/cs_idle", tag), 32'(sd_cs_n), 32'd1);
    check($sformatf("%s/stream_len", tag), 32'(tx.size()), 32'(exp_q.size()));
    check($sformatf("%s/first_diff", tag), 32'(first_diff), 32'hFFFF_FFFF);
    check($sformatf("%s/tokens", tag), 32'(fe_cnt), 32'(exp_fe));
    check($sformatf("%s/fb_addr_errs", tag), 32'(addr_err), 32'd0);
    check($sformatf("%s/handshake_errs", tag), 32'(proto_err), 32'd0);
    check($sformatf("%s/cs_busy_errs", tag), 32'(cs_err), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check($sformatf("%s/spi_start", tag), 32'(spi_bus.spi_start), 32'd0);
    check($sformatf("%s/spi_data_in", tag), 32'(spi_bus.spi_data_in), 32'hFF);
    check($sformatf("%s/sd_cs_n", tag), 32'(sd_cs_n), 32'd1);
    check($sformatf("%s/fb_addr", tag), 32'(fb_addr), 32'd0);
    check($sformatf("%s/busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s/done", tag), 32'(done), 32'd0);
    check($sformatf("%s/error", tag), 32'(error), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) fb_mem[i] = 16'($urandom);
    fb_mem[0] = 16'hABCD;
    fb_mem[1] = 16'h1234;
    fb_mem[256] = 16'h5A5A;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    // image 1: one 0xFF before R1, three busy bytes; each block frame is 528 bytes
    set_card(1, 8'h00, 8'hE5, 3);
    run_image("full_img1", 1, 1'b0, 1'b0);
    check("img1/first_addr", {tx[1], tx[2], tx[3], tx[4]}, 32'(1 * BLK));
    check("img1/last_addr", {tx[2*528+1], tx[2*528+2], tx[2*528+3], tx[2*528+4]}, 32'(1 * BLK + BLK - 1));
    check("img1/first_pixels", {tx[9], tx[10], tx[11], tx[12]}, 32'hABCD_1234);
    check("img1/block1_pixel0", {16'd0, tx[537], tx[538]}, 32'h5A5A);

    for (int i = 0; i < 1024; i++) fb_mem[i] = 16'($urandom);
    set_card($urandom_range(0, 7), 8'h00, {3'($urandom_range(0, 7)), 5'b00101}, $urandom_range(0, 15));
    run_image("rand_full", $urandom_range(0, 3), 1'b1, 1'b1);

    set_card(0, 8'h04, 8'hE5, 0);
    run_image("r1_reject", 0, 1'b0, 1'b0);
    set_card(2, 8'h00, 8'h0B, 0);
    run_image("crc_reject", 3, 1'b0, 1'b0);
    set_card(0, 8'hFF, 8'hE5, 0);
    run_image("r1_timeout", 2, 1'b0, 1'b0);
    set_card(7, 8'h00, 8'hE5, BT - 1);
    run_image("poll_limits", 1, 1'b0, 1'b0);
    set_card(0, 8'h00, 8'hE5, BT);
    run_image("busy_timeout", 0, 1'b0, 1'b0);

    // reset while the low byte of a block-1 pixel is in flight
    set_card($urandom_range(0, 3), 8'h00, 8'hE5, $urandom_range(0, 5));
    prep();
    arm_rst = 1'b1;
    lo_hit = 1'b0;
    @(negedge clk); #1;
    image_index = 2'd2;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20000 && !lo_hit; k++) @(negedge clk);
    #1;
    check("mid_reset/reached_data_lo", 32'(lo_hit), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_values("mid_reset");
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    arm_rst = 1'b0;
    run_image("after_reset", 2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sd_block_writer.md
# sd_block_writer

Streams one 320×240 RGB565 image (300 blocks of 512 bytes) from the frame buffer to an already-initialised SDHC card in SPI mode, using single-block writes (CMD24). It drives the same byte-level SPI engine handshake as the SD read path and is the save path of the image store. Images are stored at block `image_index*BLOCKS_PER_IMAGE`. The read path loads images from that same location.

## Interface
- `BLOCKS_PER_IMAGE`, 300, blocks per image; pixels per image = `BLOCKS_PER_IMAGE*256`.
- `R1_TIMEOUT`, 8, maximum 0xFF polls while waiting for R1 after a command.
- `BUSY_TIMEOUT`, 65535, maximum 0x00 polls while the card is busy after data.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle request to write an image; ignored while `busy`=1.
- `image_index` in 2: image slot, sampled on accepted `start`.
- `spi_start` out 1: one-cycle pulse requesting one SPI byte exchange.
- `spi_data_in` out 8: byte to transmit; valid in the `spi_start` cycle.
- `spi_done` in 1: one-cycle pulse, exchange complete.
- `spi_data_out` in 8: received byte; valid in the `spi_done` cycle.
- `sd_cs_n` out 1: card select, active-low.
- `fb_addr` out 17: frame-buffer pixel address (0..76799).
- `fb_data` in 16: frame-buffer pixel; valid 1 cycle after `fb_addr` changes.
- `busy` out 1: an image write is in progress.
- `done` out 1: one-cycle pulse at the end of an image write, on success or error.
- `error` out 1: sticky failure flag; cleared on the next accepted `start`.

## Operation
- Exactly one `spi_start` per byte. The next `spi_start` is issued no earlier than the cycle after `spi_done`.
- A byte's `spi_done` result is consumed only in the state that issued the byte.
- States:
  - IDLE.
  - CMD: sends 6 bytes: 0x58, addr[31:24], addr[23:16], addr[15:8], addr[7:0], 0xFF.
  - R1: polls with 0xFF.
  - TOKEN: sends 0xFE.
  - FETCH: drives `fb_addr` and waits 1 cycle, then latches `fb_data`.
  - DATA_HI: sends pixel[15:8].
  - DATA_LO: sends pixel[7:0].
  - CRC: sends 0xFF, 0xFF.
  - DRESP: polls with 0xFF.
  - BUSY: polls with 0xFF.
  - NEXT.
  - FINISH.
- IDLE → CMD on accepted `start`. This clears `error`, sets `busy` and `sd_cs_n`=0, block_index=0 and pixel counter=0.
- addr = `image_index*BLOCKS_PER_IMAGE + block_index`, 32 bits, zero-extended.
- R1:
  - received 0xFF: poll again, up to `R1_TIMEOUT` polls;
  - received 0x00: go to TOKEN;
  - any other value, or timeout: error.
- TOKEN → FETCH.
- Per block, the FETCH/DATA_HI/DATA_LO loop runs 256 times. `fb_addr` = block_index*256 + word and increments by 1 per pixel.
- After the 256th DATA_LO: go to CRC (2 bytes), then DRESP.
- DRESP:
  - received 0xFF: keep polling, up to `R1_TIMEOUT` polls;
  - otherwise evaluate `spi_data_out[4:0]`: 5'b00101 → BUSY; any other value → error.
- BUSY: 0x00 means still busy, keep polling up to `BUSY_TIMEOUT` polls. Any nonzero byte → NEXT.
- NEXT:
  - if block_index = `BLOCKS_PER_IMAGE-1`, go to FINISH;
  - otherwise increment block_index and go to CMD.
- FINISH: `sd_cs_n`=1, `busy`=0, `done`=1 for one cycle, then IDLE.
- Error path: set `error`=1, then handle exactly as FINISH. No further blocks are attempted.

## Timing
- Reset values: `spi_start`=0, `spi_data_in`=0xFF, `sd_cs_n`=1, `fb_addr`=0, `busy`=0, `done`=0, `error`=0, state IDLE.
- Reset asserted mid-operation forces these values immediately and abandons the partial block.
- `start` accepted → `sd_cs_n`=0 and `busy`=1 in the next cycle. The first `spi_start` (0x58) follows one cycle later.
- `sd_cs_n` stays low continuously from the first command byte until FINISH, including between blocks.
- FETCH takes 2 cycles (address, then latch). The DATA_HI `spi_start` is issued in the cycle after the latch.
- `done` and the final `error` value become valid in the same cycle. `busy` falls in that same cycle.
- `start` arriving in the `done` cycle is ignored. `start` is accepted from IDLE on the following cycle.
- All arithmetic is unsigned. block_index is 9 bits and the pixel counter is 17 bits, so neither wraps within one image.

## Test plan
- Full write, `image_index`=1, card model returns R1 0x00 after one 0xFF, data response 0xE5, then three 0x00 busy bytes → first frame is 58 00 00 01 2C FF and the last is 58 00 00 02 57 FF. Exactly 300 FE tokens are sent, `done` pulses once, `error`=0, `sd_cs_n`=1 afterwards.
- Frame buffer pixel0=0xABCD, pixel1=0x1234, block 1 pixel0=0x5A5A → bytes after the first FE are AB CD 12 34. The first data bytes of block 1 are 5A 5A, with `fb_addr`=256 at that point.
- R1 = 0x04 for the first command → `error`=1 and `done` pulse. No 0xFE is ever sent, and `sd_cs_n` returns high.
- Data response 0x0B (CRC rejected) on block 0 → `error`=1. No second CMD24 is issued.
- Card returns all 0xFF after the command → exactly 8 R1 polls, then `error`=1. The next `start` clears `error`.
- `start` pulsed while `busy` → ignored, with a single `done` at the end. Reset asserted during DATA_LO → all outputs equal their reset values in the same cycle. A following `start` rewrites from block 0.
